// File: rtl/sha_stream_arbiter.sv
// Round-robin arbiter sharing one single-context SHA3 stream core between NUM_REQ
// AXI-Stream requesters; the lock is held from grant until the core's result stream ends.
module sha_stream_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic                          ACLK,
  input  logic                          ARESETn,
  input  logic [NUM_REQ-1:0]            s_TVALID,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] s_TDATA,
  input  logic [NUM_REQ-1:0]            s_TLAST,
  input  logic [NUM_REQ*4-1:0]          s_TUSER,
  output logic [NUM_REQ-1:0]            s_TREADY,
  output logic                          m_TVALID,
  output logic [DATA_WIDTH-1:0]         m_TDATA,
  output logic                          m_TLAST,
  output logic [3:0]                    m_TUSER,
  output logic [ID_WIDTH-1:0]           m_TID,
  input  logic                          m_TREADY,
  input  logic                          r_TVALID,
  input  logic                          r_TLAST,
  input  logic                          r_TREADY,
  output logic [ID_WIDTH-1:0]           res_id,
  output logic                          busy,
  output logic                          timeout_err
);

  // state    | meaning
  // ST_IDLE  | no owner; pick next requester round-robin from r_rr_ptr
  // ST_FWD   | granted requester's message is muxed through to the core
  // ST_WAIT  | message sent; core locked until result TLAST or timeout

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t              r_state;
  logic [ID_WIDTH-1:0] r_grant;
  logic [ID_WIDTH-1:0] r_rr_ptr;
  logic [ID_WIDTH-1:0] r_res_id;
  logic [CNT_W-1:0]    r_wait_cnt;
  logic                r_busy;
  logic                r_timeout_err;

  logic [ID_WIDTH-1:0] w_pick;
  logic                w_found;
  int                  w_idx;
  logic [NUM_REQ-1:0]  w_vshift;
  logic                w_last_beat;
  logic                w_res_done;
  logic                w_timeout;
  logic [ID_WIDTH-1:0] w_rr_next;

  // First valid requester at or after r_rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    w_pick   = r_rr_ptr;
    w_found  = 1'b0;
    w_idx    = 0;
    w_vshift = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = int'(r_rr_ptr) + k;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      w_vshift = s_TVALID >> w_idx;
      if (!w_found && w_vshift[0]) begin
        w_pick  = ID_WIDTH'(w_idx);
        w_found = 1'b1;
      end
    end
  end

  always_comb begin
    s_TREADY = '0;
    m_TVALID = 1'b0;
    m_TDATA  = '0;
    m_TLAST  = 1'b0;
    m_TUSER  = '0;
    m_TID    = '0;
    if (r_state == ST_FWD) begin
      m_TVALID          = s_TVALID[r_grant];
      m_TDATA           = s_TDATA[r_grant*DATA_WIDTH +: DATA_WIDTH];
      m_TLAST           = s_TLAST[r_grant];
      m_TUSER           = s_TUSER[r_grant*4 +: 4];
      m_TID             = r_grant;
      s_TREADY[r_grant] = m_TREADY;
    end
  end

  assign w_last_beat = m_TVALID & m_TREADY & m_TLAST;
  assign w_res_done  = r_TVALID & r_TREADY & r_TLAST;
  assign w_timeout   = (r_wait_cnt == CNT_W'(TIMEOUT - 1));
  assign w_rr_next   = (r_grant == ID_WIDTH'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state       <= ST_IDLE;
      r_grant       <= '0;
      r_rr_ptr      <= '0;
      r_res_id      <= '0;
      r_wait_cnt    <= '0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_grant <= w_pick;
            r_busy  <= 1'b1;
            r_state <= ST_FWD;
          end
        end
        ST_FWD: begin
          if (w_last_beat) begin
            r_wait_cnt <= '0;
            r_res_id   <= r_grant;
            r_state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A final result beat takes precedence over an expiring timer.
          if (w_res_done) begin
            r_rr_ptr <= w_rr_next;
            r_busy   <= 1'b0;
            r_state  <= ST_IDLE;
          end else if (w_timeout) begin
            r_timeout_err <= 1'b1;
            r_rr_ptr      <= w_rr_next;
            r_busy        <= 1'b0;
            r_state       <= ST_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign res_id      = r_res_id;
  assign busy        = r_busy;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_sha_stream_arbiter.sv
// Directed bench for sha_stream_arbiter: grant order, lock holding, timeout and reset.
module tb_sha_stream_arbiter;
  localparam int DW = 16;
  localparam int NR = 4;
  localparam int IW = 2;

  logic             ACLK;
  logic             ARESETn;
  logic [NR-1:0]    s_TVALID;
  logic [NR*DW-1:0] s_TDATA;
  logic [NR-1:0]    s_TLAST;
  logic [NR*4-1:0]  s_TUSER;
  logic [NR-1:0]    s_TREADY;
  logic             m_TVALID;
  logic [DW-1:0]    m_TDATA;
  logic             m_TLAST;
  logic [3:0]       m_TUSER;
  logic [IW-1:0]    m_TID;
  logic             m_TREADY;
  logic             r_TVALID;
  logic             r_TLAST;
  logic             r_TREADY;
  logic [IW-1:0]    res_id;
  logic             busy;
  logic             timeout_err;

  logic [DW-1:0]    tb_data [NR];
  logic [3:0]       tb_user [NR];
  int               n_vec;
  int               n_err;
  int               seq [5];
  logic             saw_bad;

  sha_stream_arbiter #(
    .DATA_WIDTH(DW), .NUM_REQ(NR), .ID_WIDTH(IW), .TIMEOUT(64)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .s_TVALID(s_TVALID), .s_TDATA(s_TDATA), .s_TLAST(s_TLAST), .s_TUSER(s_TUSER),
    .s_TREADY(s_TREADY),
    .m_TVALID(m_TVALID), .m_TDATA(m_TDATA), .m_TLAST(m_TLAST), .m_TUSER(m_TUSER),
    .m_TID(m_TID), .m_TREADY(m_TREADY),
    .r_TVALID(r_TVALID), .r_TLAST(r_TLAST), .r_TREADY(r_TREADY),
    .res_id(res_id), .busy(busy), .timeout_err(timeout_err)
  );

  always_comb begin
    s_TDATA = '0;
    s_TUSER = '0;
    for (int i = 0; i < NR; i++) begin
      s_TDATA[i*DW +: DW] = tb_data[i];
      s_TUSER[i*4 +: 4]   = tb_user[i];
    end
  end

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic result_beat();
    r_TVALID = 1'b1;
    r_TLAST  = 1'b1;
    r_TREADY = 1'b1;
    tick();
    r_TVALID = 1'b0;
    r_TLAST  = 1'b0;
    r_TREADY = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    seq = '{0, 1, 2, 3, 0};
    ARESETn  = 1'b0;
    s_TVALID = '0;
    s_TLAST  = '0;
    m_TREADY = 1'b0;
    r_TVALID = 1'b0;
    r_TLAST  = 1'b0;
    r_TREADY = 1'b0;
    for (int i = 0; i < NR; i++) begin
      tb_data[i] = '0;
      tb_user[i] = '0;
    end
    tick();
    tick();
    chk("rst_ctrl", {s_TREADY, m_TVALID, m_TLAST, m_TUSER, m_TID, res_id, busy, timeout_err}, 32'h0);
    chk("rst_data", m_TDATA, 32'h0);

    // Single requester 1, three beats with stalls.
    ARESETn     = 1'b1;
    s_TVALID    = 4'b0010;
    tb_data[1]  = 16'h1111;
    tb_user[1]  = 4'h5;
    m_TREADY    = 1'b1;
    settle();
    chk("t1_grant_latency", m_TVALID, 32'h0);
    tick();
    chk("t1_tid", m_TID, 32'h1);
    chk("t1_d0", m_TDATA, 32'h1111);
    chk("t1_tready", s_TREADY, 32'h2);
    chk("t1_tuser", m_TUSER, 32'h5);
    chk("t1_busy", busy, 32'h1);
    m_TREADY = 1'b0;
    settle();
    chk("t1_stall_rdy", s_TREADY, 32'h0);
    tick();
    chk("t1_stall_d0", m_TDATA, 32'h1111);
    m_TREADY = 1'b1;
    tick();
    tb_data[1] = 16'h2222;
    settle();
    chk("t1_d1", m_TDATA, 32'h2222);
    tick();
    tb_data[1] = 16'h3333;
    s_TLAST[1] = 1'b1;
    settle();
    chk("t1_d2", {m_TLAST, m_TDATA}, 32'h13333);
    tick();
    s_TVALID = '0;
    s_TLAST  = '0;
    settle();
    chk("t1_wait_mvalid", {m_TVALID, s_TREADY}, 32'h0);
    chk("t1_res_id", res_id, 32'h1);
    chk("t1_wait_busy", busy, 32'h1);
    result_beat();
    chk("t1_release", busy, 32'h0);

    // All four requesters contend; rr_ptr starts from 0 after a reset.
    ARESETn = 1'b0;
    settle();
    ARESETn = 1'b1;
    settle();
    for (int i = 0; i < NR; i++) tb_data[i] = 16'(16'hA000 + i * 16);
    s_TVALID = 4'b1111;
    s_TLAST  = 4'b0000;
    for (int m = 0; m < 5; m++) begin
      tick();
      chk("t2_tid", m_TID, 32'(seq[m]));
      chk("t2_onehot_rdy", s_TREADY, 32'(1 << seq[m]));
      chk("t2_beat0", m_TDATA, 32'(16'hA000 + seq[m] * 16));
      tick();
      tb_data[seq[m]] = 16'(16'hA001 + seq[m] * 16);
      s_TLAST[seq[m]] = 1'b1;
      settle();
      chk("t2_beat1", {m_TLAST, m_TDATA}, 32'h10000 | 32'(16'hA001 + seq[m] * 16));
      tick();
      tb_data[seq[m]] = 16'(16'hA000 + seq[m] * 16);
      s_TLAST[seq[m]] = 1'b0;
      chk("t2_wait", {m_TVALID, s_TREADY}, 32'h0);
      chk("t2_res_id", res_id, 32'(seq[m]));
      result_beat();
    end

    // Requester 2 pauses mid-message while requester 0 waits; result beats in FWD ignored.
    s_TVALID   = 4'b0101;
    tb_data[2] = 16'h2A01;
    tb_data[0] = 16'h0B01;
    tick();
    chk("t3_tid", m_TID, 32'h2);
    tick();
    s_TVALID[2] = 1'b0;
    r_TVALID = 1'b1;
    r_TLAST  = 1'b1;
    r_TREADY = 1'b1;
    for (int k = 0; k < 5; k++) begin
      settle();
      chk("t3_hold", {m_TVALID, m_TID, s_TREADY}, 32'h24);
      tick();
    end
    r_TVALID    = 1'b0;
    r_TLAST     = 1'b0;
    r_TREADY    = 1'b0;
    s_TVALID[2] = 1'b1;
    tb_data[2]  = 16'h2A02;
    s_TLAST[2]  = 1'b1;
    settle();
    chk("t3_resume", {m_TID, m_TLAST, m_TDATA}, 32'h52A02);
    tick();
    s_TVALID[2] = 1'b0;
    s_TLAST[2]  = 1'b0;
    chk("t3_res_id", res_id, 32'h2);
    result_beat();

    // Timeout: requester 0 sends one beat, no result ever arrives.
    s_TLAST[0] = 1'b1;
    tick();
    chk("t4_tid", m_TID, 32'h0);
    tick();
    s_TVALID[0] = 1'b0;
    s_TLAST[0]  = 1'b0;
    saw_bad = 1'b0;
    for (int k = 0; k < 63; k++) begin
      tick();
      if (timeout_err !== 1'b0 || busy !== 1'b1) saw_bad = 1'b1;
    end
    chk("t4_no_early_release", saw_bad, 32'h0);
    tick();
    chk("t4_timeout_pulse", {busy, timeout_err}, 32'h1);
    s_TVALID   = 4'b0011;
    tb_data[0] = 16'h0C01;
    tb_data[1] = 16'h1C01;
    s_TLAST[1] = 1'b1;
    tick();
    chk("t4_pulse_end", timeout_err, 32'h0);
    chk("t4_next_grant", m_TID, 32'h1);

    // Final result beat on the last timer cycle releases cleanly.
    tick();
    s_TVALID[1] = 1'b0;
    s_TLAST[1]  = 1'b0;
    saw_bad = 1'b0;
    for (int k = 0; k < 63; k++) begin
      tick();
      if (timeout_err !== 1'b0 || busy !== 1'b1) saw_bad = 1'b1;
    end
    chk("t5_no_early_release", saw_bad, 32'h0);
    result_beat();
    chk("t5_clean_release", {busy, timeout_err}, 32'h0);
    tick();
    chk("t5_next_grant", {timeout_err, m_TID}, 32'h0);

    // Reset during beat 2 of requester 0; rr_ptr must restart at 0.
    tick();
    tb_data[0] = 16'h0C02;
    settle();
    chk("t6_beat2", m_TDATA, 32'h0C02);
    s_TVALID   = 4'b0101;
    tb_data[2] = 16'h2D01;
    ARESETn    = 1'b0;
    #1;
    chk("t6_rst_ctrl", {s_TREADY, m_TVALID, m_TID, busy}, 32'h0);
    chk("t6_rst_data", m_TDATA, 32'h0);
    ARESETn = 1'b1;
    tick();
    chk("t6_regrant", {m_TID, m_TDATA}, 32'h00C02);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
